noc_traffic_gen: RTL and testbench

Parametrised, runtime-configurable flit traffic generator driving the per-node `data_input` injection bus of `spidergon_top`. It supersedes the hard-coded per-node reset-time stimulus with selectable traffic patterns, multi-flit packets, round-robin virtual-channel tagging and per-node valid/ready flow control. Completion is reported with a done pulse and a flit counter for soak and deadlock runs.

---
 rtl/noc_traffic_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_noc_traffic_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_gen.sv
// Runtime-configurable flit traffic generator for the spidergon per-node injection bus.
// Each node runs a small IDLE/SEND sequencer; outputs are registered from next-state values.
module noc_traffic_gen #(
  parameter int NUM_OF_NODES            = 8,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int MAX_PKT_LEN             = 8,
  parameter int PKT_COUNT_WIDTH         = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [1:0]                            mode,
  input  logic [$clog2(MAX_PKT_LEN+1)-1:0]      pkt_len,
  input  logic [PKT_COUNT_WIDTH-1:0]            num_pkts,
  output logic [NUM_OF_NODES*(2+$clog2(NUM_OF_VIRTUAL_CHANNELS)+FLIT_DATA_WIDTH)-1:0] data_input,
  output logic [NUM_OF_NODES-1:0]               flit_valid,
  input  logic [NUM_OF_NODES-1:0]               flit_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic [31:0]                           flits_sent
);

  localparam int N   = NUM_OF_NODES;
  localparam int FDW = FLIT_DATA_WIDTH;
  localparam int VW  = $clog2(NUM_OF_VIRTUAL_CHANNELS);
  localparam int FTW = 2 + VW + FDW;
  localparam int DW  = $clog2(NUM_OF_NODES);
  localparam int IW  = $clog2(MAX_PKT_LEN);
  localparam int LW  = $clog2(MAX_PKT_LEN+1);
  localparam int PCW = PKT_COUNT_WIDTH;

  localparam logic [LW-1:0]  LEN_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]  IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [PCW-1:0] REM_ONE = {{(PCW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0]  VC_ONE  = {{(VW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} node_state_t;

  node_state_t          state_r  [N];
  node_state_t          state_nx [N];
  logic [IW-1:0]        idx_r    [N];
  logic [IW-1:0]        idx_nx   [N];
  logic [PCW-1:0]       rem_r    [N];
  logic [PCW-1:0]       rem_nx   [N];
  logic [VW-1:0]        vc_r     [N];
  logic [VW-1:0]        vc_nx    [N];

  logic [N*FTW-1:0]     data_r;
  logic [N*FTW-1:0]     data_nx_s;
  logic [N-1:0]         valid_r;
  logic [N-1:0]         valid_nx_s;
  logic [N-1:0]         hs_s;
  logic [31:0]          hs_cnt_s;
  logic [31:0]          flits_sent_r;
  logic                 busy_r;
  logic                 done_r;
  logic [1:0]           mode_r;
  logic [LW-1:0]        len_r;
  logic [1:0]           cfg_mode_s;
  logic [LW-1:0]        cfg_len_s;
  logic                 start_acc_s;
  logic                 all_idle_s;
  logic                 run_s;

  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
    if (len == '0) begin
      eff_len = LEN_ONE;
    end else if (len > LW'(MAX_PKT_LEN)) begin
      eff_len = LW'(MAX_PKT_LEN);
    end else begin
      eff_len = len;
    end
  endfunction

  function automatic logic is_source(input logic [1:0] m, input logic [DW-1:0] node);
    case (m)
      2'd0:    is_source = (node == DW'(1));
      2'd1:    is_source = (node == DW'(1)) || (node == DW'(2));
      2'd2:    is_source = (node == DW'(1)) || (node == DW'(2)) ||
                           (node == DW'(N-2)) || (node == DW'(N-1));
      2'd3:    is_source = 1'b1;
      default: is_source = 1'b0;
    endcase
  endfunction

  // Head/single flits carry routing info; body/tail flits carry source and position.
  function automatic logic [FTW-1:0] build_flit(input logic [LW-1:0] len,
                                                 input logic [IW-1:0] idx,
                                                 input logic [VW-1:0] vc,
                                                 input logic [DW-1:0] src,
                                                 input logic [DW-1:0] dest);
    logic [1:0]     ftype;
    logic [FDW-1:0] payload;
    logic [LW-1:0]  idx_ext;
    idx_ext = LW'(idx);
    payload = '0;
    if (len == LEN_ONE) begin
      ftype = 2'b11;
    end else if (idx_ext == '0) begin
      ftype = 2'b01;
    end else if (idx_ext == len - LEN_ONE) begin
      ftype = 2'b00;
    end else begin
      ftype = 2'b10;
    end
    if (idx_ext == '0) begin
      payload[FDW-1 -: DW]    = dest;
      payload[FDW-DW-1 -: DW] = src;
    end else begin
      payload[IW +: DW]  = src;
      payload[IW-1:0]    = idx;
    end
    build_flit = {ftype, vc, payload};
  endfunction

  // Per-node next-state, next-flit and handshake accounting.
  always_comb begin
    start_acc_s = start & ~busy_r;
    if (start_acc_s) begin
      cfg_mode_s = mode;
      cfg_len_s  = eff_len(pkt_len);
    end else begin
      cfg_mode_s = mode_r;
      cfg_len_s  = len_r;
    end
    all_idle_s = 1'b1;
    hs_cnt_s   = '0;
    hs_s       = '0;
    data_nx_s  = '0;
    valid_nx_s = '0;
    for (int n = 0; n < N; n++) begin
      hs_s[n]     = valid_r[n] & flit_ready[n];
      hs_cnt_s    = hs_cnt_s + {31'b0, hs_s[n]};
      state_nx[n] = state_r[n];
      idx_nx[n]   = idx_r[n];
      rem_nx[n]   = rem_r[n];
      vc_nx[n]    = vc_r[n];
      case (state_r[n])
        ST_IDLE: begin
          if (start_acc_s && is_source(cfg_mode_s, DW'(n)) && (num_pkts != '0)) begin
            state_nx[n] = ST_SEND;
            idx_nx[n]   = '0;
            rem_nx[n]   = num_pkts;
            vc_nx[n]    = '0;
          end else begin
            state_nx[n] = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (hs_s[n]) begin
            if (LW'(idx_r[n]) == cfg_len_s - LEN_ONE) begin
              if (rem_r[n] == REM_ONE) begin
                state_nx[n] = ST_IDLE;
              end else begin
                rem_nx[n] = rem_r[n] - REM_ONE;
                idx_nx[n] = '0;
                vc_nx[n]  = vc_r[n] + VC_ONE;
              end
            end else begin
              idx_nx[n] = idx_r[n] + IDX_ONE;
            end
          end else begin
            state_nx[n] = ST_SEND;
          end
        end
        default: state_nx[n] = ST_IDLE;
      endcase
      if (state_nx[n] == ST_SEND) begin
        all_idle_s    = 1'b0;
        valid_nx_s[n] = 1'b1;
        data_nx_s[n*FTW +: FTW] = build_flit(cfg_len_s, idx_nx[n], vc_nx[n], DW'(n),
                                             (cfg_mode_s == 2'd3) ? DW'(n + 1) : '0);
      end else begin
        valid_nx_s[n] = 1'b0;
        data_nx_s[n*FTW +: FTW] = '0;
      end
    end
    run_s = busy_r | start_acc_s;
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      flits_sent_r <= '0;
      mode_r       <= 2'd0;
      len_r        <= LEN_ONE;
      valid_r      <= '0;
      data_r       <= '0;
      for (int n = 0; n < N; n++) begin
        state_r[n] <= ST_IDLE;
        idx_r[n]   <= '0;
        rem_r[n]   <= '0;
        vc_r[n]    <= '0;
      end
    end else begin
      busy_r  <= run_s & ~all_idle_s;
      done_r  <= run_s & all_idle_s;
      valid_r <= valid_nx_s;
      data_r  <= data_nx_s;
      if (start_acc_s) begin
        flits_sent_r <= '0;
        mode_r       <= mode;
        len_r        <= eff_len(pkt_len);
      end else begin
        flits_sent_r <= flits_sent_r + hs_cnt_s;
      end
      for (int n = 0; n < N; n++) begin
        state_r[n] <= state_nx[n];
        idx_r[n]   <= idx_nx[n];
        rem_r[n]   <= rem_nx[n];
        vc_r[n]    <= vc_nx[n];
      end
    end
  end

  assign data_input = data_r;
  assign flit_valid = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign flits_sent = flits_sent_r;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Self-checking bench for noc_traffic_gen: per-node expected flit lists built from the
// packet format rules, replayed cycle by cycle against scripted or random backpressure.
module tb_noc_traffic_gen;

  localparam int N   = 8;
  localparam int FTW = 19;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [3:0]       pkt_len;
  logic [7:0]       num_pkts;
  logic [N*FTW-1:0] data_input;
  logic [N-1:0]     flit_valid;
  logic [N-1:0]     flit_ready;
  logic             busy;
  logic             done;
  logic [31:0]      flits_sent;

  int checks   = 0;
  int failures = 0;

  logic [FTW-1:0] exp_flit [N][2048];
  int             exp_cnt  [N];
  int             exp_pos  [N];

  noc_traffic_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .pkt_len(pkt_len),
    .num_pkts(num_pkts), .data_input(data_input), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .busy(busy), .done(done), .flits_sent(flits_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_len(int len);
    if (len == 0) return 1;
    if (len > 8) return 8;
    return len;
  endfunction

  function automatic bit ref_src(int m, int n);
    case (m)
      0:       return n == 1;
      1:       return n == 1 || n == 2;
      2:       return n == 1 || n == 2 || n == 6 || n == 7;
      default: return 1'b1;
    endcase
  endfunction

  // Expected flit stream of every node, written directly from the packet format rules.
  task automatic build_model(input int m, input int len, input int np);
    int L;
    int t;
    int payload;
    int dest;
    L = ref_len(len);
    for (int n = 0; n < N; n++) begin
      exp_cnt[n] = 0;
      exp_pos[n] = 0;
      dest = (m == 3) ? (n + 1) % N : 0;
      if (ref_src(m, n)) begin
        for (int p = 0; p < np; p++) begin
          for (int i = 0; i < L; i++) begin
            if (L == 1)          t = 3;
            else if (i == 0)     t = 1;
            else if (i == L - 1) t = 0;
            else                 t = 2;
            if (i == 0) payload = dest * 8192 + n * 1024;
            else        payload = n * 8 + i;
            exp_flit[n][exp_cnt[n]] = FTW'(t * 131072 + (p % 2) * 65536 + payload);
            exp_cnt[n] = exp_cnt[n] + 1;
          end
        end
      end
    end
  endtask

  // rmode: 0 all ready, 1 random, 2 node 6 stalled in cycles 1..4.
  task automatic run_and_check(input int m, input int len, input int np, input int rmode,
                               input int restart_at, output int done_cyc,
                               output logic [N*FTW-1:0] first_data);
    int               cyc;
    int               sent;
    bit               empty;
    logic [N-1:0]     rdy;
    logic [N-1:0]     exp_valid;
    logic [N*FTW-1:0] exp_data;
    build_model(m, len, np);
    mode     = 2'(m);
    pkt_len  = 4'(len);
    num_pkts = 8'(np);
    start    = 1'b1;
    tick();
    start      = 1'b0;
    cyc        = 1;
    sent       = 0;
    done_cyc   = -1;
    first_data = data_input;
    while (cyc < 3000 && done_cyc < 0) begin
      case (rmode)
        1:       rdy = 8'($urandom);
        2:       begin rdy = '1; if (cyc >= 1 && cyc <= 4) rdy[6] = 1'b0; end
        default: rdy = '1;
      endcase
      flit_ready = rdy;
      if (cyc == restart_at) begin
        start    = 1'b1;
        mode     = 2'(m ^ 1);
        pkt_len  = 4'd1;
        num_pkts = 8'd1;
      end else begin
        start = 1'b0;
      end
      empty     = 1'b1;
      exp_valid = '0;
      exp_data  = '0;
      for (int n = 0; n < N; n++) begin
        if (exp_pos[n] < exp_cnt[n]) begin
          empty = 1'b0;
          exp_valid[n] = 1'b1;
          exp_data[n*FTW +: FTW] = exp_flit[n][exp_pos[n]];
        end
      end
      checks++;
      if (flit_valid !== exp_valid) begin
        failures++;
        $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, flit_valid, exp_valid);
      end
      checks++;
      if (data_input !== exp_data) begin
        failures++;
        $display("FAIL data cyc=%0d got=%h exp=%h", cyc, data_input, exp_data);
      end
      checks++;
      if (flits_sent !== 32'(sent)) begin
        failures++;
        $display("FAIL flits_sent cyc=%0d got=%0d exp=%0d", cyc, flits_sent, sent);
      end
      checks++;
      if (done !== empty || busy !== !empty) begin
        failures++;
        $display("FAIL done_busy cyc=%0d got=%b%b exp=%b%b", cyc, done, busy, empty, !empty);
      end
      if (empty) done_cyc = cyc;
      for (int n = 0; n < N; n++) begin
        if (exp_valid[n] && rdy[n]) begin
          exp_pos[n] = exp_pos[n] + 1;
          sent = sent + 1;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL timeout got=no_done exp=done");
    end else if (done !== 1'b0 || busy !== 1'b0 || flits_sent !== 32'(sent)) begin
      failures++;
      $display("FAIL after_done got=%b%b/%0d exp=00/%0d", done, busy, flits_sent, sent);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 2'd0; pkt_len = 4'd1; num_pkts = 8'd0; flit_ready = '0;
    tick();
    tick();
    checks++;
    if (data_input !== '0 || flit_valid !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        flits_sent !== 32'd0) begin
      failures++;
      $display("FAIL reset got=%b/%b/%b/%0d exp=all_zero", flit_valid, busy, done, flits_sent);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_flit_mode3();
    int               dc;
    logic [N*FTW-1:0] fd;
    logic [FTW-1:0]   n7;
    run_and_check(3, 1, 1, 0, -1, dc, fd);
    checks++;
    if (dc !== 2) begin failures++; $display("FAIL single_done_cycle got=%0d exp=2", dc); end
    checks++;
    if (fd[3*FTW +: FTW] !== 19'h68C00) begin
      failures++; $display("FAIL single_node3 got=%h exp=68c00", fd[3*FTW +: FTW]);
    end
    n7 = fd[7*FTW +: FTW];
    checks++;
    if (n7[15:13] !== 3'd0) begin failures++; $display("FAIL single_node7_dest got=%0d exp=0", n7[15:13]); end
    checks++;
    if (flits_sent !== 32'd8) begin failures++; $display("FAIL single_count got=%0d exp=8", flits_sent); end
  endtask

  task automatic test_multi_packet();
    int               dc;
    logic [N*FTW-1:0] fd;
    run_and_check(0, 3, 2, 0, -1, dc, fd);
    checks++;
    if (dc !== 7) begin failures++; $display("FAIL multi_done_cycle got=%0d exp=7", dc); end
    checks++;
    if (flits_sent !== 32'd6) begin failures++; $display("FAIL multi_count got=%0d exp=6", flits_sent); end
  endtask

  task automatic test_backpressure();
    int               dc;
    logic [N*FTW-1:0] fd;
    run_and_check(2, 2, 1, 2, -1, dc, fd);
    checks++;
    if (dc !== 7) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=7", dc); end
  endtask

  task automatic test_zero_pkts();
    int               dc;
    logic [N*FTW-1:0] fd;
    run_and_check(1, 3, 0, 0, -1, dc, fd);
    checks++;
    if (dc !== 1 || flits_sent !== 32'd0) begin
      failures++; $display("FAIL zero_pkts got=%0d/%0d exp=1/0", dc, flits_sent);
    end
  endtask

  task automatic test_busy_restart();
    int               dc;
    logic [N*FTW-1:0] fd;
    run_and_check(3, 2, 3, 0, 2, dc, fd);
    checks++;
    if (dc !== 7) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=7", dc); end
  endtask

  task automatic test_reset_mid();
    int               dc;
    int               seen;
    logic [N*FTW-1:0] fd;
    mode = 2'd3; pkt_len = 4'd4; num_pkts = 8'd2; flit_ready = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (data_input !== '0 || flit_valid !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        flits_sent !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b/%b/%0d exp=all_zero", flit_valid, busy, done, flits_sent);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0 || flit_valid !== '0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_reset_quiet got=%0d exp=0", seen); end
    run_and_check(3, 3, 2, 1, -1, dc, fd);
  endtask

  task automatic test_random();
    int               dc;
    logic [N*FTW-1:0] fd;
    for (int r = 0; r < 8; r++) begin
      run_and_check($urandom_range(3, 0), $urandom_range(15, 0), $urandom_range(6, 0),
                    1, -1, dc, fd);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_flit_mode3();
    test_multi_packet();
    test_backpressure();
    test_zero_pkts();
    test_busy_restart();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
